multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore sequencing of fetch/decode/execute steps
// with memory wait handshake and a debug view of the current state.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 when memory ready
// DECODE  | register read, branch target precompute, dispatch on Opcode
// MEMADR  | effective address = A + sign-extended imm
// MEMRD   | data read at ALUOut, waits on MemReady
// MEMWB   | load result written to rt
// MEMWR   | data write at ALUOut, waits on MemReady
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result written to rd
// BRANCH  | BEQ compare, conditional PC load
// JUMP    | PC load from jump target
module multicycle_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  stateT curState;
  stateT nextState;

  always_ff @(posedge Clk) begin
    if (Reset) curState <= FETCH;
    else       curState <= nextState;
  end

  assign State = curState;

  always_comb begin
    nextState   = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    InstrDone   = 1'b0;
    IllegalOp   = 1'b0;

    case (curState)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        nextState = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default: begin
            nextState = FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nextState = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        nextState = MemReady ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
      end
      default: nextState = FETCH;
    endcase

    // Reset silences every strobe immediately, even before the first edge lands.
    if (Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      InstrDone   = 1'b0;
      IllegalOp   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed instruction scenarios plus randomized opcode,
// wait-state and reset-abort stimulus against an instruction-level model.
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst, InstrDone, IllegalOp;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;

  always #5 Clk = ~Clk;

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .State(State), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  logic [17:0] ctrlVec;
  assign ctrlVec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                    ALUSrcB, InstrDone, IllegalOp};

  int checkCount = 0;
  int errCount   = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: state walk, latency and control table by state.
  int  path[$];
  int  idx, cyc, waits, doneSeen;
  bit  done, prevReset;

  function automatic bit isLegal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
  endfunction

  function automatic int baseLatency(input logic [5:0] op);
    case (op)
      6'd35:        return 5;
      6'd43, 6'd0:  return 4;
      6'd4, 6'd2:   return 3;
      default:      return 2;
    endcase
  endfunction

  task automatic loadPath(input logic [5:0] op);
    case (op)
      6'd35:   path = '{0, 1, 2, 3, 4};
      6'd43:   path = '{0, 1, 2, 5};
      6'd0:    path = '{0, 1, 6, 7};
      6'd4:    path = '{0, 1, 8};
      6'd2:    path = '{0, 1, 9};
      default: path = '{0, 1};
    endcase
  endtask

  function automatic logic [17:0] expCtrl(input int st, input bit rdy, input logic [5:0] op);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, dn, ill;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, dn, ill} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin asb = 2'b11; ill = !isLegal(op); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; iord = 1; dn = rdy; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; dn = 1; end
      8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; dn = 1; end
      9: begin pcw = 1; pcs = 2'b10; dn = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, pcs, aop, asb, dn, ill};
  endfunction

  task automatic stepCycle(input bit rst, input bit rdy, input logic [5:0] op);
    int st;
    @(negedge Clk);
    Reset = rst; MemReady = rdy; Opcode = op;
    #1;
    if (rst) begin
      checkEq("rstOutputs", {14'd0, ctrlVec}, 32'd0);
      if (prevReset) checkEq("rstState", {28'd0, State}, 32'd0);
      prevReset = 1;
      done = 1;
    end else begin
      prevReset = 0;
      st = path[idx];
      checkEq("state", {28'd0, State}, st);
      checkEq("ctrl", {14'd0, ctrlVec}, {14'd0, expCtrl(st, rdy, op)});
      checkEq("rdWrExclusive", {31'd0, MemRead & MemWrite}, 32'd0);
      if (InstrDone) doneSeen++;
      cyc++;
      if ((st == 0 || st == 3 || st == 5) && !rdy) waits++;
      else idx++;
      if (idx == path.size()) begin
        checkEq("latency", cyc, baseLatency(op) + waits);
        checkEq("doneCount", doneSeen, isLegal(op) ? 1 : 0);
        done = 1;
      end
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) stepCycle(1, $urandom_range(0, 1), Opcode);
  endtask

  // abortState >= 0 injects rstLen reset cycles when the model reaches that state.
  task automatic doInstr(input logic [5:0] op, input int fw, input int mw,
                         input int abortState, input int rstLen);
    int fwLeft, mwLeft, st;
    bit rdy;
    loadPath(op);
    idx = 0; cyc = 0; waits = 0; doneSeen = 0; done = 0;
    fwLeft = fw; mwLeft = mw;
    for (int n = 0; n < 64 && !done; n++) begin
      st = path[idx];
      if (st == abortState) begin
        for (int r = 0; r < rstLen; r++) stepCycle(1, 1, op);
      end else begin
        rdy = 1;
        if (st == 0 && fwLeft > 0) begin rdy = 0; fwLeft--; end
        else if ((st == 3 || st == 5) && mwLeft > 0) begin rdy = 0; mwLeft--; end
        stepCycle(0, rdy, op);
      end
    end
    if (!done) checkEq("timeout", 32'd0, 32'd1);
  endtask

  logic [5:0] opTable [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};

  initial begin
    logic [5:0] op;
    int abortAt;
    prevReset = 0;
    doReset(2);
    doInstr(6'd35, 0, 0, -1, 0);
    doInstr(6'd43, 0, 2, -1, 0);
    doInstr(6'd0, 0, 0, -1, 0);
    doInstr(6'd4, 0, 0, -1, 0);
    doInstr(6'd2, 3, 0, -1, 0);
    doInstr(6'd8, 0, 0, -1, 0);
    doInstr(6'd35, 0, 3, 3, 2);
    doInstr(6'd35, 1, 1, -1, 0);
    doInstr(6'd43, 0, 0, 2, 1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
      else op = opTable[$urandom_range(0, 4)];
      abortAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      doInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), abortAt,
              $urandom_range(1, 2));
    end
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
